// File: rtl/mcycle_pkg.sv
// Shared constants for the multi-cycle control FSM: opcodes, states, instruction
// classes and the mux select encodings driven to the datapath.
package mcycle_pkg;

  localparam logic [6:0] ITYPE   = 7'b0010011;
  localparam logic [6:0] RTYPE   = 7'b0110011;
  localparam logic [6:0] BTYPE   = 7'b1100011;
  localparam logic [6:0] J_ITYPE = 7'b1100111;
  localparam logic [6:0] LOAD    = 7'b0000011;
  localparam logic [6:0] STORE   = 7'b0100011;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] AUIPC   = 7'b0010111;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_ITYPE, CLS_LUI, CLS_AUIPC, CLS_JAL,
    CLS_JALR, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
  } cls_e;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_ALU = 2'd1;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic       ALU_A_REG  = 1'b0;
  localparam logic       ALU_A_PC   = 1'b1;
  localparam logic [1:0] ALU_B_REG  = 2'd0;
  localparam logic [1:0] ALU_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_B_FOUR = 2'd2;

  typedef struct packed {
    logic       ir_we;
    logic       oldpc_we;
    logic       pc_we;
    logic       reg_we;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] pc_src;
    logic [1:0] wb_sel;
  } ctrl_t;

endpackage

// File: rtl/mcycle_if.sv
// Memory handshake between the control FSM (master) and the memory port (slave).
interface mcycle_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mcycle_decode.sv
// Opcode to instruction-class map; anything unlisted is flagged illegal.
module mcycle_decode
  import mcycle_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls,
  output logic       illegal
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      RTYPE:   cls = CLS_RTYPE;
      ITYPE:   cls = CLS_ITYPE;
      LUI:     cls = CLS_LUI;
      AUIPC:   cls = CLS_AUIPC;
      JAL:     cls = CLS_JAL;
      J_ITYPE: cls = CLS_JALR;
      LOAD:    cls = CLS_LOAD;
      STORE:   cls = CLS_STORE;
      BTYPE:   cls = CLS_BRANCH;
      default: cls = CLS_ILLEGAL;
    endcase
    illegal = (cls == CLS_ILLEGAL);
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle RISC-V control FSM. Strobes are registered: a strobe issued by a
// state is seen on the following cycle. MCYCLE_TRAP_EN enables the TRAP state.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7,
  input  logic       br_cond,
  mcycle_if.master   mem,
  output logic       ir_we,
  output logic       oldpc_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [2:0] alu_func3,
  output logic       alu_func7,
  output logic [6:0] alu_opcode,
  output logic [2:0] state,
  output logic       fault
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [7:0] wait_q, wait_d;
  cls_e       cls;
  logic       illegal, done, stall, timeout;
  logic       is_jump;

  mcycle_decode u_decode (.opcode(opcode), .cls(cls), .illegal(illegal));

  // mem_ready only counts while our own request is on the bus
  assign done    = ctrl_q.mem_req & mem.mem_ready;
  assign stall   = ctrl_q.mem_req & ~mem.mem_ready;
  assign is_jump = (cls == CLS_JAL) || (cls == CLS_JALR);

`ifdef MCYCLE_TRAP_EN
  localparam state_e ILLEGAL_NXT = TRAP;
  assign timeout = stall & (wait_q == MAX_W);
`else
  localparam state_e ILLEGAL_NXT = FETCH;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (done) state_d = DECODE;
               else if (timeout) state_d = TRAP;
      DECODE:  state_d = EXECUTE;
      EXECUTE: begin
        if (illegal) state_d = ILLEGAL_NXT;
        else begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_d = MEM;
            CLS_BRANCH:          state_d = FETCH;
            default:             state_d = WB;
          endcase
        end
      end
      MEM:     if (done) state_d = (cls == CLS_STORE) ? FETCH : WB;
               else if (timeout) state_d = TRAP;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ctrl_d         = '0;
    ctrl_d.mem_req = (state_d == FETCH) || (state_d == MEM);
    ctrl_d.mem_we  = (state_d == MEM) && (cls == CLS_STORE);
    unique case (state_q)
      FETCH: begin
        ctrl_d.ir_we    = done;
        ctrl_d.oldpc_we = done;
      end
      EXECUTE: begin
        // branches and illegal-as-NOP both retire straight back to FETCH
        ctrl_d.pc_we  = (state_d == FETCH);
        ctrl_d.pc_src = (cls == CLS_BRANCH && br_cond) ? PC_SRC_ALU : PC_SRC_PC4;
      end
      MEM: ctrl_d.pc_we = done && (cls == CLS_STORE);
      WB: begin
        ctrl_d.reg_we = 1'b1;
        ctrl_d.pc_we  = 1'b1;
        ctrl_d.pc_src = is_jump ? PC_SRC_ALU : PC_SRC_PC4;
        ctrl_d.wb_sel = (cls == CLS_LOAD) ? WB_SEL_MEM :
                        is_jump           ? WB_SEL_PC4 : WB_SEL_ALU;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_d == FETCH || state_d == MEM) && state_d != state_q) wait_d = '0;
    else if (stall && wait_q != MAX_W)                              wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      wait_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      wait_q <= wait_d;
    end
  end

`ifdef MCYCLE_TRAP_EN
  logic fault_q, fault_d;
  always_comb fault_d = fault_q | (state_d == TRAP);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // ALU controls: outside EXECUTE the ALU computes old PC + 4
  always_comb begin
    alu_opcode = ITYPE;
    alu_func3  = 3'b000;
    alu_func7  = 1'b0;
    alu_a_sel  = ALU_A_PC;
    alu_b_sel  = ALU_B_FOUR;
    if (state_q == EXECUTE) begin
      case (cls)
        CLS_RTYPE: begin
          alu_opcode = opcode; alu_func3 = func3; alu_func7 = func7;
          alu_a_sel  = ALU_A_REG; alu_b_sel = ALU_B_REG;
        end
        CLS_ITYPE: begin
          alu_opcode = opcode; alu_func3 = func3;
          alu_func7  = (func3 == 3'b101) & func7;
          alu_a_sel  = ALU_A_REG; alu_b_sel = ALU_B_IMM;
        end
        CLS_LUI, CLS_AUIPC: begin
          alu_opcode = opcode; alu_func3 = func3;
          alu_a_sel  = (cls == CLS_AUIPC) ? ALU_A_PC : ALU_A_REG;
          alu_b_sel  = ALU_B_IMM;
        end
        CLS_JALR, CLS_LOAD, CLS_STORE: begin
          alu_a_sel = ALU_A_REG; alu_b_sel = ALU_B_IMM;
        end
        CLS_JAL, CLS_BRANCH: begin
          alu_a_sel = ALU_A_PC; alu_b_sel = ALU_B_IMM;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req = ctrl_q.mem_req;
  assign mem.mem_we  = ctrl_q.mem_we;
  assign ir_we       = ctrl_q.ir_we;
  assign oldpc_we    = ctrl_q.oldpc_we;
  assign pc_we       = ctrl_q.pc_we;
  assign reg_we      = ctrl_q.reg_we;
  assign pc_src      = ctrl_q.pc_src;
  assign wb_sel      = ctrl_q.wb_sel;
  assign state       = state_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl (MAX_WAIT=4); expected outputs are queued per
// cycle and compared after each rising edge. Covers both MCYCLE_TRAP_EN builds.
module tb_mcycle_ctrl;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, irwe, opcwe, pcwe, regwe;
    logic [1:0] pcs, wbs;
    logic       flt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7, br_cond;
  logic       ir_we, oldpc_we, pc_we, reg_we, alu_a_sel, alu_func7, fault;
  logic [1:0] pc_src, wb_sel, alu_b_sel;
  logic [2:0] alu_func3, state;
  logic [6:0] alu_opcode;

  mcycle_if mem_bus ();

  mcycle_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
    .br_cond(br_cond), .mem(mem_bus), .ir_we(ir_we), .oldpc_we(oldpc_we),
    .pc_we(pc_we), .reg_we(reg_we), .pc_src(pc_src), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_func3(alu_func3),
    .alu_func7(alu_func7), .alu_opcode(alu_opcode), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  obs_t  obs;
  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  assign obs = {state, mem_bus.mem_req, mem_bus.mem_we, ir_we, oldpc_we, pc_we,
                reg_we, pc_src, wb_sel, fault};

`ifdef MCYCLE_TRAP_EN
  localparam int TF = 1;
`else
  localparam int TF = 0;
`endif

  function automatic obs_t mk(int st, int req, int we, int ir, int opc, int pcw,
                              int rw, int ps, int ws, int f);
    return {3'(st), 1'(req), 1'(we), 1'(ir), 1'(opc), 1'(pcw), 1'(rw),
            2'(ps), 2'(ws), 1'(f)};
  endfunction

  task automatic compare(string tag, obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(string tag, obs_t exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    compare(tag_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic chk_alu(string tag, int op, int f3, int f7, int a, int b);
    logic [13:0] got, want;
    got  = {alu_opcode, alu_func3, alu_func7, alu_a_sel, alu_b_sel};
    want = {7'(op), 3'(f3), 1'(f7), 1'(a), 2'(b)};
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    opcode = '0; func3 = '0; func7 = 1'b0; br_cond = 1'b0;
    mem_bus.mem_ready = 1'b0; rst_n = 1'b0;
    #12;
    compare("reset", mk(0,0,0,0,0,0,0,0,0,0));
    @(negedge clk); rst_n = 1'b1;
    cyc("first fetch req", mk(0,1,0,0,0,0,0,0,0,0));

    // add (sub encoding: func7 must pass through)
    opcode = OP_R; func3 = 3'b000; func7 = 1'b1; mem_bus.mem_ready = 1'b1;
    cyc("add decode", mk(1,0,0,1,1,0,0,0,0,0)); mem_bus.mem_ready = 1'b0;
    cyc("add execute", mk(2,0,0,0,0,0,0,0,0,0));
    chk_alu("add alu", OP_R, 0, 1, 0, 0);
    cyc("add wb", mk(4,0,0,0,0,0,0,0,0,0));
    cyc("add reg_we", mk(0,1,0,0,0,1,1,0,0,0));

    // lw with three wait cycles in MEM
    opcode = OP_LD; func3 = 3'b010; func7 = 1'b0; mem_bus.mem_ready = 1'b1;
    cyc("lw decode", mk(1,0,0,1,1,0,0,0,0,0)); mem_bus.mem_ready = 1'b0;
    cyc("lw execute", mk(2,0,0,0,0,0,0,0,0,0));
    chk_alu("lw alu", OP_I, 0, 0, 0, 1);
    cyc("lw mem", mk(3,1,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++) cyc("lw mem wait", mk(3,1,0,0,0,0,0,0,0,0));
    mem_bus.mem_ready = 1'b1;
    cyc("lw wb", mk(4,0,0,0,0,0,0,0,0,0)); mem_bus.mem_ready = 1'b0;
    cyc("lw reg_we", mk(0,1,0,0,0,1,1,0,1,0));

    // beq taken then not taken; func7=1 must be forced to 0
    opcode = OP_B; func3 = 3'b000; func7 = 1'b1; mem_bus.mem_ready = 1'b1;
    cyc("beq1 decode", mk(1,0,0,1,1,0,0,0,0,0)); mem_bus.mem_ready = 1'b0;
    cyc("beq1 execute", mk(2,0,0,0,0,0,0,0,0,0));
    chk_alu("beq alu", OP_I, 0, 0, 1, 1);
    br_cond = 1'b1;
    cyc("beq taken", mk(0,1,0,0,0,1,0,1,0,0));
    br_cond = 1'b0; mem_bus.mem_ready = 1'b1;
    cyc("beq2 decode", mk(1,0,0,1,1,0,0,0,0,0)); mem_bus.mem_ready = 1'b0;
    cyc("beq2 execute", mk(2,0,0,0,0,0,0,0,0,0));
    cyc("beq not taken", mk(0,1,0,0,0,1,0,0,0,0));

    // sw interrupted by reset in MEM
    opcode = OP_ST; func3 = 3'b010; func7 = 1'b0; mem_bus.mem_ready = 1'b1;
    cyc("sw decode", mk(1,0,0,1,1,0,0,0,0,0)); mem_bus.mem_ready = 1'b0;
    cyc("sw execute", mk(2,0,0,0,0,0,0,0,0,0));
    chk_alu("sw alu", OP_I, 0, 0, 0, 1);
    cyc("sw mem", mk(3,1,1,0,0,0,0,0,0,0));
    cyc("sw mem wait", mk(3,1,1,0,0,0,0,0,0,0));
    #2 rst_n = 1'b0;
    #1 compare("sw async reset", mk(0,0,0,0,0,0,0,0,0,0));
    mem_bus.mem_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    opcode = OP_JAL;
    cyc("ready ignored w/o req", mk(0,1,0,0,0,0,0,0,0,0));

    // jal after clean fetch
    cyc("jal decode", mk(1,0,0,1,1,0,0,0,0,0)); mem_bus.mem_ready = 1'b0;
    cyc("jal execute", mk(2,0,0,0,0,0,0,0,0,0));
    chk_alu("jal alu", OP_I, 0, 0, 1, 1);
    cyc("jal wb", mk(4,0,0,0,0,0,0,0,0,0));
    cyc("jal reg_we", mk(0,1,0,0,0,1,1,1,2,0));

    // fetch ready exactly when the wait counter sits at MAX_WAIT; srai
    opcode = OP_I; func3 = 3'b101; func7 = 1'b1;
    for (int i = 0; i < 4; i++) cyc("srai fetch wait", mk(0,1,0,0,0,0,0,0,0,0));
    mem_bus.mem_ready = 1'b1;
    cyc("srai decode at max", mk(1,0,0,1,1,0,0,0,0,0)); mem_bus.mem_ready = 1'b0;
    cyc("srai execute", mk(2,0,0,0,0,0,0,0,0,0));
    chk_alu("srai alu", OP_I, 5, 1, 0, 1);
    cyc("srai wb", mk(4,0,0,0,0,0,0,0,0,0));
    cyc("srai reg_we", mk(0,1,0,0,0,1,1,0,0,0));

    // unknown opcode
    opcode = 7'b0000000; func3 = 3'b000; func7 = 1'b0; mem_bus.mem_ready = 1'b1;
    cyc("illegal decode", mk(1,0,0,1,1,0,0,0,0,0)); mem_bus.mem_ready = 1'b0;
    cyc("illegal execute", mk(2,0,0,0,0,0,0,0,0,0));
`ifdef MCYCLE_TRAP_EN
    cyc("illegal trap", mk(5,0,0,0,0,0,0,0,0,TF));
    mem_bus.mem_ready = 1'b1;
    cyc("trap hold", mk(5,0,0,0,0,0,0,0,0,TF));
    @(negedge clk); rst_n = 1'b0;
    #1 compare("trap reset", mk(0,0,0,0,0,0,0,0,0,0));
    mem_bus.mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cyc("refetch after trap", mk(0,1,0,0,0,0,0,0,0,0));
`else
    cyc("illegal nop", mk(0,1,0,0,0,1,0,0,0,0));
`endif

    // memory never answers
    opcode = OP_R;
    for (int i = 0; i < 4; i++) cyc("timeout wait", mk(0,1,0,0,0,0,0,0,0,0));
`ifdef MCYCLE_TRAP_EN
    cyc("timeout trap", mk(5,0,0,0,0,0,0,0,0,TF));
    cyc("timeout trap hold", mk(5,0,0,0,0,0,0,0,0,TF));
`else
    cyc("timeout ignored", mk(0,1,0,0,0,0,0,0,0,0));
    cyc("timeout still fetch", mk(0,1,0,0,0,0,0,0,0,0));
`endif

    rst_n = 1'b0;
    #1 compare("final reset", mk(0,0,0,0,0,0,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: memory wait cycles before timeout, range 1..255.
REQ-002 SHALL have port clk  input  1: single clock, all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port opcode  input  7: opcode field of the instruction register.
REQ-005 SHALL have port func3  input  3: func3 field of the instruction register.
REQ-006 SHALL have port func7  input  1: instruction bit 30.
REQ-007 SHALL have port br_cond  input  1: branch comparison result, valid in EXECUTE.
REQ-008 SHALL have port mem_req  output  1: memory request, held until mem_ready.
REQ-009 SHALL have port mem_we  output  1: store qualifier, valid with mem_req.
REQ-010 SHALL have port mem_ready  input  1: memory completion, sampled while mem_req=1.
REQ-011 SHALL have ports ir_we, oldpc_we, pc_we, reg_we  output  1 each: datapath register write strobes.
REQ-012 SHALL have port pc_src  output  2: 0=PC+4, 1=ALU result (branch/jump target).
REQ-013 SHALL have port wb_sel  output  2: 0=ALU, 1=memory data, 2=old PC+4.
REQ-014 SHALL have ports alu_a_sel 1, alu_b_sel 2  output: 0=reg/1=old PC; 0=reg/1=imm/2=const 4.
REQ-015 SHALL have ports alu_func3 3, alu_func7 1, alu_opcode 7  output: ALU controls.
REQ-016 SHALL have ports state  output  3 (encoding in REQ-018) and fault  output  1 (sticky error).

Function
REQ-017 SHALL register all strobes and state; alu_func3/alu_func7/alu_opcode SHALL be combinational from state and inputs.
REQ-018 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.
REQ-019 FETCH: mem_req=1, mem_we=0; on mem_ready, ir_we=1 and oldpc_we=1 for one cycle, then DECODE.
REQ-020 DECODE SHALL last exactly one cycle, then EXECUTE.
REQ-021 EXECUTE: R/I-type ALU ops, LUI, AUIPC, JAL, JALR go to WB; LOAD/STORE go to MEM; BRANCH goes to FETCH.
REQ-022 For R-type and for I-type func3=101, ALU controls SHALL pass opcode/func3/func7. Otherwise func7 SHALL be forced to 0.
REQ-023 Address, target and PC+4 computations SHALL force the ALU add controls: ITYPE opcode, func3=000, func7=0.
REQ-024 BRANCH in EXECUTE: pc_we=1; pc_src=1 if br_cond=1, else 0.
REQ-025 MEM: mem_req=1, mem_we=1 for STORE; on mem_ready, LOAD goes to WB and STORE goes to FETCH with pc_we=1 and pc_src=0.
REQ-026 WB: reg_we=1, pc_we=1; pc_src=1 for JAL/JALR, else 0; wb_sel=1 for LOAD, 2 for JAL/JALR, else 0; then FETCH.
REQ-027 A wait counter SHALL clear on entering FETCH/MEM, increment per cycle with mem_req=1 and mem_ready=0, and saturate at MAX_WAIT.
REQ-028 mem_ready=1 in the same cycle the counter reaches MAX_WAIT SHALL complete normally, with no timeout.
REQ-029 mem_ready while mem_req=0 SHALL be ignored.
REQ-030 No instruction SHALL assert more than one of ir_we and reg_we in the same cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force state=FETCH, all strobes=0, mem_req=0, fault=0 and wait counter=0, including mid-MEM.
REQ-032 After release, the first mem_req SHALL rise on the first clock edge.

Configuration
REQ-033 Macro MCYCLE_TRAP_EN defined: an unknown opcode in EXECUTE or a wait counter reaching MAX_WAIT SHALL enter TRAP.
REQ-034 TRAP SHALL set fault=1, hold all strobes and mem_req at 0, and exit only by reset.
REQ-035 Macro undefined: an unknown opcode SHALL act as a NOP (pc_we=1, pc_src=0, go to FETCH); timeouts SHALL be ignored; fault SHALL be tied 0; TRAP SHALL be unreachable.

Structure
REQ-036 A shared package mcycle_pkg SHALL hold the opcode constants (ITYPE, RTYPE, BTYPE, J_ITYPE, LOAD, STORE, JAL, LUI, AUIPC), the state enum and the pc_src/wb_sel/alu_b_sel encodings.
REQ-037 A sub-module mcycle_decode SHALL map opcode to instruction class plus an illegal flag.

Verification
REQ-038 add, mem_ready one cycle after mem_req -> states 0,1,2,4,0; reg_we=1 in WB, 5 cycles total.
REQ-039 lw, MEM ready after 3 wait cycles -> mem_req held 4 cycles in MEM, wb_sel=1, 9 cycles total.
REQ-040 beq with br_cond=1 -> pc_we=1, pc_src=1 in EXECUTE; with br_cond=0 -> pc_src=0; next state FETCH.
REQ-041 MAX_WAIT=4, mem_ready held 0 -> with macro, TRAP at counter=4 and fault=1; without macro, mem_req held and state stays FETCH.
REQ-042 rst_n low mid-MEM of a sw -> mem_req=0 and state=0 asynchronously; after release, a clean fetch.
REQ-043 opcode 7'b0000000 -> with macro, state=5 and fault=1; without macro, pc_we pulse and return to FETCH.
